// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared types and constants for the video timing generator.
//   vt_mode_e : test-pattern select (black, colour bars, gradient, grid)
//   bar_rgb() : colour-bar index -> {r_on, g_on, b_on}
//   VT640_* / VT1440_* : standard 640x480 and 1440x900 timing sets
package video_timing_pkg;

    typedef enum logic [1:0] {
        VT_BLACK = 2'd0,
        VT_BARS  = 2'd1,
        VT_GRAD  = 2'd2,
        VT_GRID  = 2'd3
    } vt_mode_e;

    // 640x480 @ 60 Hz
    localparam int VT640_H_SYNC   = 96;
    localparam int VT640_H_BACK   = 48;
    localparam int VT640_H_ACTIVE = 640;
    localparam int VT640_H_FRONT  = 16;
    localparam int VT640_V_SYNC   = 2;
    localparam int VT640_V_BACK   = 33;
    localparam int VT640_V_ACTIVE = 480;
    localparam int VT640_V_FRONT  = 10;

    // 1440x900 @ 60 Hz
    localparam int VT1440_H_SYNC   = 152;
    localparam int VT1440_H_BACK   = 232;
    localparam int VT1440_H_ACTIVE = 1440;
    localparam int VT1440_H_FRONT  = 80;
    localparam int VT1440_V_SYNC   = 6;
    localparam int VT1440_V_BACK   = 25;
    localparam int VT1440_V_ACTIVE = 900;
    localparam int VT1440_V_FRONT  = 3;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black falls
    // out of inverting individual index bits per channel.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

endpackage

// File: rtl/vt_axis_counter.sv
// vt_axis_counter
// One timing axis: counts 0..TOTAL-1 on each enabled cycle and wraps.
// Phase order is sync, back porch, active, front porch; count 0 is the
// first sync cycle.
//   pixel_clock : clock
//   reset_n     : synchronous active-low reset
//   step        : advance the count this cycle
//   count       : current position on the axis
//   sync        : count inside the sync phase
//   active      : count inside the active window
//   wrap        : count is at its last value and is stepping back to 0
module vt_axis_counter #(
    parameter int SYNC   = 3,
    parameter int BACK   = 4,
    parameter int ACTIVE = 16,
    parameter int FRONT  = 2,
    parameter int CNT_W  = 12
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_BEG  = CNT_W'(SYNC + BACK);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(SYNC + BACK + ACTIVE);

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    assign wrap   = step && (count == LAST);
    assign sync   = (count < SYNC_END);
    assign active = (count >= ACT_BEG) && (count < ACT_END);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Single-clock video timing generator with built-in test patterns.
// Every output is registered and reflects the counter position of the
// previous cycle, so all outputs share one cycle of latency.
//   pixel_clock : sole clock
//   reset_n     : synchronous active-low reset
//   mode        : pattern select, taken only at the start of a frame
//   hsync/vsync : syncs, asserted level HS_POL / VS_POL
//   de          : active-area enable
//   x/y         : active coordinates, 0 outside the active area
//   line_start  : first active pixel of each active line
//   frame_start : pixel (0,0) of each frame
//   r/g/b       : test video, 0 outside the active area
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_SYNC   = VT1440_H_SYNC,
    parameter int H_BACK   = VT1440_H_BACK,
    parameter int H_ACTIVE = VT1440_H_ACTIVE,
    parameter int H_FRONT  = VT1440_H_FRONT,
    parameter int V_SYNC   = VT1440_V_SYNC,
    parameter int V_BACK   = VT1440_V_BACK,
    parameter int V_ACTIVE = VT1440_V_ACTIVE,
    parameter int V_FRONT  = VT1440_V_FRONT,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [R_W-1:0]   r,
    output logic [G_W-1:0]   g,
    output logic [B_W-1:0]   b
);

    localparam logic [CNT_W-1:0] H_BEG    = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_BEG    = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] hc, vc;
    logic             h_sync, h_act, h_wrap;
    logic             v_sync, v_act, v_wrap;

    vt_axis_counter #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .CNT_W(CNT_W)
    ) u_h_axis (
        .pixel_clock(pixel_clock),
        .reset_n    (reset_n),
        .step       (1'b1),
        .count      (hc),
        .sync       (h_sync),
        .active     (h_act),
        .wrap       (h_wrap)
    );

    // The line counter steps on the horizontal wrap, so both axes wrap in
    // the same cycle at the end of a frame.
    vt_axis_counter #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .CNT_W(CNT_W)
    ) u_v_axis (
        .pixel_clock(pixel_clock),
        .reset_n    (reset_n),
        .step       (h_wrap),
        .count      (vc),
        .sync       (v_sync),
        .active     (v_act),
        .wrap       (v_wrap)
    );

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

    vt_mode_e         mode_q;
    logic [CNT_W-1:0] bar_pix;
    logic [2:0]       bar_idx;

    logic             de_c, line_start_c, frame_start_c;
    logic [CNT_W-1:0] x_c, y_c;
    logic [2:0]       bar_on;
    logic             grid_on;
    logic [R_W-1:0]   pat_r;
    logic [G_W-1:0]   pat_g;
    logic [B_W-1:0]   pat_b;

    assign de_c          = h_act && v_act;
    assign x_c           = de_c ? hc - H_BEG : '0;
    assign y_c           = de_c ? vc - V_BEG : '0;
    assign line_start_c  = de_c && (hc == H_BEG);
    assign frame_start_c = line_start_c && (vc == V_BEG);

    always_comb begin
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        bar_on  = bar_rgb(bar_idx);
        grid_on = (x_c[3:0] == 4'd0) || (y_c[3:0] == 4'd0);
        if (de_c) begin
            case (mode_q)
                VT_BARS: begin
                    pat_r = {R_W{bar_on[2]}};
                    pat_g = {G_W{bar_on[1]}};
                    pat_b = {B_W{bar_on[0]}};
                end
                VT_GRAD: begin
                    pat_r = x_c[R_W-1:0];
                    pat_g = x_c[G_W-1:0];
                    pat_b = y_c[B_W-1:0];
                end
                VT_GRID: begin
                    pat_r = {R_W{grid_on}};
                    pat_g = {G_W{grid_on}};
                    pat_b = {B_W{grid_on}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            mode_q      <= VT_BLACK;
            bar_pix     <= '0;
            bar_idx     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            if (hc == '0 && vc == '0) begin
                mode_q <= vt_mode_e'(mode);
            end
            // Bar sub-counter tracks the bar of the pixel at the current hc;
            // it sits at zero until the first active pixel of the line.
            if (h_act) begin
                if (bar_pix == BAR_LAST) begin
                    bar_pix <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_pix <= bar_pix + CNT_W'(1);
                end
            end else begin
                bar_pix <= '0;
                bar_idx <= '0;
            end
            hsync       <= h_sync ? HS_POL : ~HS_POL;
            vsync       <= v_sync ? VS_POL : ~VS_POL;
            de          <= de_c;
            x           <= x_c;
            y           <= y_c;
            line_start  <= line_start_c;
            frame_start <= frame_start_c;
            r           <= pat_r;
            g           <= pat_g;
            b           <= pat_b;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int HSY = 3, HBP = 4, HA = 16, HFP = 2;
    localparam int VSY = 2, VBP = 2, VA = 4, VFP = 1;
    localparam int HT = HSY + HBP + HA + HFP;   // 25
    localparam int VT = VSY + VBP + VA + VFP;   // 9
    localparam int FT = HT * VT;                // 225
    localparam int HB = HSY + HBP;
    localparam int VB = VSY + VBP;

    typedef struct packed {
        logic       hs, vs, de;
        logic [7:0] x, y;
        logic       ls, fs;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } vid_t;

    typedef struct {
        int         hc;
        int         vc;
        logic [1:0] m;
        logic       de;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } vec_t;

    logic       pixel_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       hsync_p, vsync_p, de_p, line_start_p, frame_start_p;
    logic [7:0] x_p, y_p;
    logic [4:0] r_p, b_p;
    logic [5:0] g_p;
    logic       hsync_n, vsync_n, de_n, line_start_n, frame_start_n;
    logic [7:0] x_n, y_n;
    logic [4:0] r_n, b_n;
    logic [5:0] g_n;

    int n_checks = 0;
    int n_pass = 0;
    int pos = 0;
    logic [1:0] frame_mode = 2'd0;

    always #5 pixel_clock = ~pixel_clock;

    video_timing_gen #(
        .H_SYNC(HSY), .H_BACK(HBP), .H_ACTIVE(HA), .H_FRONT(HFP),
        .V_SYNC(VSY), .V_BACK(VBP), .V_ACTIVE(VA), .V_FRONT(VFP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8), .R_W(5), .G_W(6), .B_W(5)
    ) dut_p (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .mode(mode),
        .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .x(x_p), .y(y_p),
        .line_start(line_start_p), .frame_start(frame_start_p),
        .r(r_p), .g(g_p), .b(b_p)
    );

    video_timing_gen #(
        .H_SYNC(HSY), .H_BACK(HBP), .H_ACTIVE(HA), .H_FRONT(HFP),
        .V_SYNC(VSY), .V_BACK(VBP), .V_ACTIVE(VA), .V_FRONT(VFP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(8), .R_W(5), .G_W(6), .B_W(5)
    ) dut_n (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .mode(mode),
        .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .x(x_n), .y(y_n),
        .line_start(line_start_n), .frame_start(frame_start_n),
        .r(r_n), .g(g_n), .b(b_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Colour-bar palette by bar number, as {r_on, g_on, b_on}.
    function automatic logic [2:0] bar_colour(input int i);
        case (i)
            0: return 3'b111;  // white
            1: return 3'b110;  // yellow
            2: return 3'b011;  // cyan
            3: return 3'b010;  // green
            4: return 3'b101;  // magenta
            5: return 3'b100;  // red
            6: return 3'b001;  // blue
            default: return 3'b000;  // black
        endcase
    endfunction

    function automatic vid_t reset_val(input logic pol);
        vid_t v;
        v = '0;
        v.hs = ~pol;
        v.vs = ~pol;
        return v;
    endfunction

    // Expected outputs for frame position p (row-major, 0 = first sync pixel).
    function automatic vid_t model(input int p, input logic [1:0] m, input logic pol);
        vid_t v;
        int hc, vc, xi, yi;
        logic [2:0] on;
        v = '0;
        hc = p % HT;
        vc = p / HT;
        v.hs = (hc < HSY) ? pol : ~pol;
        v.vs = (vc < VSY) ? pol : ~pol;
        v.de = (hc >= HB) && (hc < HB + HA) && (vc >= VB) && (vc < VB + VA);
        if (v.de) begin
            xi = hc - HB;
            yi = vc - VB;
            v.x = 8'(xi);
            v.y = 8'(yi);
            v.ls = (xi == 0);
            v.fs = (xi == 0) && (yi == 0);
            case (m)
                2'd1: begin
                    on = bar_colour(xi / (HA / 8));
                    v.r = on[2] ? 5'd31 : 5'd0;
                    v.g = on[1] ? 6'd63 : 6'd0;
                    v.b = on[0] ? 5'd31 : 5'd0;
                end
                2'd2: begin
                    v.r = 5'(xi % 32);
                    v.g = 6'(xi % 64);
                    v.b = 5'(yi % 32);
                end
                2'd3: begin
                    if ((xi % 16 == 0) || (yi % 16 == 0)) begin
                        v.r = 5'd31;
                        v.g = 6'd63;
                        v.b = 5'd31;
                    end
                end
                default: ;
            endcase
        end
        return v;
    endfunction

    // One clock: drive inputs, predict, clock, compare both polarities.
    task automatic cyc(input logic rst_in, input logic [1:0] m);
        vid_t ep, en, ap, an;
        int nxt;
        reset_n = rst_in;
        mode = m;
        if (!rst_in) begin
            ep = reset_val(1'b1);
            en = reset_val(1'b0);
            nxt = 0;
        end else begin
            if (pos == 0) frame_mode = m;
            ep = model(pos, frame_mode, 1'b1);
            en = model(pos, frame_mode, 1'b0);
            nxt = (pos + 1) % FT;
        end
        @(posedge pixel_clock);
        #1;
        ap = {hsync_p, vsync_p, de_p, x_p, y_p, line_start_p, frame_start_p, r_p, g_p, b_p};
        an = {hsync_n, vsync_n, de_n, x_n, y_n, line_start_n, frame_start_n, r_n, g_n, b_n};
        check($sformatf("model_pos_pol@%0d", pos), 64'(ap), 64'(ep));
        check($sformatf("model_neg_pol@%0d", pos), 64'(an), 64'(en));
        pos = nxt;
    endtask

    // Clock until the outputs reflect frame position (th, tv).
    task automatic run_to(input int th, input int tv, input logic [1:0] m);
        int target, was, n;
        target = tv * HT + th;
        n = 0;
        was = -1;
        while (was != target && n < 2 * FT) begin
            was = pos;
            cyc(1'b1, m);
            n++;
        end
        check("run_to_reached", 64'(was), 64'(target));
    endtask

    vec_t vecs[13];
    int hs_rise_prev, hs_period, hs_run, hs_width;
    int vs_run, vs_width, fs_prev, fs_period, de_cnt, x_max;
    logic prev_hs;
    int n_wait;
    logic found, rb;

    initial begin
        vecs[0]  = '{HB + 0,  VB + 0, 2'd1, 1'b1, 5'd31, 6'd63, 5'd31};
        vecs[1]  = '{HB + 1,  VB + 0, 2'd1, 1'b1, 5'd31, 6'd63, 5'd31};
        vecs[2]  = '{HB + 2,  VB + 1, 2'd1, 1'b1, 5'd31, 6'd63, 5'd0};
        vecs[3]  = '{HB + 4,  VB + 2, 2'd1, 1'b1, 5'd0,  6'd63, 5'd31};
        vecs[4]  = '{HB + 12, VB + 3, 2'd1, 1'b1, 5'd0,  6'd0,  5'd31};
        vecs[5]  = '{HB + 14, VB + 0, 2'd1, 1'b1, 5'd0,  6'd0,  5'd0};
        vecs[6]  = '{HB + 15, VB + 3, 2'd1, 1'b1, 5'd0,  6'd0,  5'd0};
        vecs[7]  = '{3,       5,      2'd1, 1'b0, 5'd0,  6'd0,  5'd0};
        vecs[8]  = '{HB + 0,  VB + 1, 2'd3, 1'b1, 5'd31, 6'd63, 5'd31};
        vecs[9]  = '{HB + 5,  VB + 1, 2'd3, 1'b1, 5'd0,  6'd0,  5'd0};
        vecs[10] = '{HB + 5,  VB + 0, 2'd3, 1'b1, 5'd31, 6'd63, 5'd31};
        vecs[11] = '{HB + 13, VB + 3, 2'd2, 1'b1, 5'd13, 6'd13, 5'd3};
        vecs[12] = '{HB + 5,  VB + 2, 2'd0, 1'b1, 5'd0,  6'd0,  5'd0};

        // Reset held for 5 cycles, then sync starts from the origin.
        for (int k = 0; k < 5; k++) cyc(1'b0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'd0);
            check($sformatf("hsync_after_release_%0d", k), 64'(hsync_p), 64'(k < 3));
            check($sformatf("vsync_after_release_%0d", k), 64'(vsync_p), 64'd1);
        end

        // Two frames of timing measurements.
        cyc(1'b0, 2'd0);
        cyc(1'b0, 2'd0);
        hs_rise_prev = -1; hs_period = 0; hs_run = 0; hs_width = 0;
        vs_run = 0; vs_width = 0; fs_prev = -1; fs_period = 0;
        de_cnt = 0; x_max = 0; prev_hs = 1'b0;
        for (int k = 0; k < 2 * FT + 5; k++) begin
            cyc(1'b1, 2'd0);
            if (hsync_p && !prev_hs) begin
                if (hs_rise_prev >= 0) hs_period = k - hs_rise_prev;
                hs_rise_prev = k;
            end
            if (hsync_p) hs_run++;
            else if (hs_run > 0) begin hs_width = hs_run; hs_run = 0; end
            if (vsync_p) vs_run++;
            else if (vs_run > 0) begin vs_width = vs_run; vs_run = 0; end
            if (frame_start_p) begin
                if (fs_prev >= 0) fs_period = k - fs_prev;
                fs_prev = k;
            end
            if (de_p && k < FT) de_cnt++;
            if (de_p && int'(x_p) > x_max) x_max = int'(x_p);
            prev_hs = hsync_p;
        end
        check("hsync_period", 64'(hs_period), 64'd25);
        check("hsync_width", 64'(hs_width), 64'd3);
        check("vsync_width", 64'(vs_width), 64'd50);
        check("frame_start_period", 64'(fs_period), 64'd225);
        check("de_per_frame", 64'(de_cnt), 64'd64);
        check("x_max", 64'(x_max), 64'd15);

        // Pattern vectors at chosen coordinates.
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, vecs[i].m);
            cyc(1'b0, vecs[i].m);
            run_to(vecs[i].hc, vecs[i].vc, vecs[i].m);
            check($sformatf("vec%0d_de", i), 64'(de_p), 64'(vecs[i].de));
            check($sformatf("vec%0d_r", i), 64'(r_p), 64'(vecs[i].r));
            check($sformatf("vec%0d_g", i), 64'(g_p), 64'(vecs[i].g));
            check($sformatf("vec%0d_b", i), 64'(b_p), 64'(vecs[i].b));
        end

        // Mode change mid-frame only takes effect at the next frame.
        cyc(1'b0, 2'd1);
        cyc(1'b0, 2'd1);
        run_to(0, 5, 2'd1);
        run_to(HB + 2, VB + 2, 2'd3);
        check("modechg_still_bars_r", 64'(r_p), 64'd31);
        check("modechg_still_bars_b", 64'(b_p), 64'd0);
        run_to(HB + 2, VB + 0, 2'd3);
        check("modechg_grid_white_b", 64'(b_p), 64'd31);
        run_to(HB + 5, VB + 1, 2'd3);
        check("modechg_grid_black_g", 64'(g_p), 64'd0);

        // One-cycle reset mid-frame restarts from the origin.
        cyc(1'b0, 2'd0);
        cyc(1'b0, 2'd0);
        run_to(10, 5, 2'd2);
        cyc(1'b0, 2'd2);
        check("midrst_de", 64'(de_p), 64'd0);
        check("midrst_frame_start", 64'(frame_start_p), 64'd0);
        check("midrst_vsync_n", 64'(vsync_n), 64'd1);
        n_wait = 0;
        found = 1'b0;
        while (!found && n_wait < 300) begin
            cyc(1'b1, 2'd2);
            n_wait++;
            if (frame_start_p) found = 1'b1;
        end
        check("midrst_frame_start_delay", 64'(n_wait), 64'd108);

        // Random modes and occasional reset pulses against the model.
        for (int k = 0; k < 4000; k++) begin
            rb = ($urandom_range(0, 599) != 0);
            cyc(rb, 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
